// File: rtl/uart_pkg.sv
// Shared UART frame constants, state encoding and baud divisor helper.
// Used by the receiver here and by the matching transmitter.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  function automatic int unsigned baud_rate(input logic [2:0] sel);
    case (sel)
      3'd0:    return 300;
      3'd1:    return 1200;
      3'd2:    return 4800;
      3'd3:    return 9600;
      3'd4:    return 19200;
      3'd5:    return 38400;
      3'd6:    return 57600;
      default: return 115200;
    endcase
  endfunction

  // Rounded clocks per oversample tick; clamped to 1 so slow clocks still tick.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input logic [2:0] sel);
    int unsigned den;
    int unsigned div;
    den = OVERSAMPLE * baud_rate(sel);
    div = (clk_hz + den / 2) / den;
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Host-side signal bundle of the UART receiver, plus a debug view of its FSM state.
interface uart_receiver_if;
  import uart_pkg::*;

  // Serial line and controls flow host->receiver; the byte and status strobes
  // flow back as single-cycle pulses with no backpressure (no ready).
  logic        RxD;
  logic        Rx_EN;
  logic [2:0]  baud_select;
  logic [7:0]  Rx_DATA;
  logic        Rx_VALID;
  logic        Rx_PERROR;
  logic        Rx_FERROR;
  uart_state_t rx_state;

  modport master (
    output RxD, Rx_EN, baud_select,
    input  Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, rx_state
  );

  modport slave (
    input  RxD, Rx_EN, baud_select,
    output Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, rx_state
  );
endinterface

// File: rtl/rx_baud_gen.sv
// 16x oversample tick generator; restarts whenever the rate selection changes.
module rx_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  output logic       o_tick
);

  localparam logic [CNT_W-1:0] DIV_TAB [8] = '{
    CNT_W'(baud_div(CLK_HZ, 3'd0)), CNT_W'(baud_div(CLK_HZ, 3'd1)),
    CNT_W'(baud_div(CLK_HZ, 3'd2)), CNT_W'(baud_div(CLK_HZ, 3'd3)),
    CNT_W'(baud_div(CLK_HZ, 3'd4)), CNT_W'(baud_div(CLK_HZ, 3'd5)),
    CNT_W'(baud_div(CLK_HZ, 3'd6)), CNT_W'(baud_div(CLK_HZ, 3'd7))
  };

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_sel;
  logic             r_tick;
  logic [CNT_W-1:0] w_div;

  assign w_div  = DIV_TAB[baud_select];
  assign o_tick = r_tick;

  always_ff @(posedge clk) begin
    r_sel <= baud_select;
    if (reset || (baud_select != r_sel)) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == w_div - 1'b1) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits LSB first, even parity, 1 stop, 16x oversampled,
// mid-bit sampling, single-cycle VALID/PERROR/FERROR strobes.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic           clk,
  input  logic           reset,
  uart_receiver_if.slave rx
);

  logic        r_sync1, r_sync2, r_prev;
  uart_state_t r_state, w_state_n;
  logic [3:0]  r_sc, w_sc_n;
  logic [2:0]  r_bc, w_bc_n;
  logic [7:0]  r_shift, w_shift_n;
  logic        r_par, w_par_n;
  logic [7:0]  r_data, w_data_n;
  logic        r_valid, w_valid_n;
  logic        r_perr, w_perr_n;
  logic        r_ferr, w_ferr_n;
  logic        w_tick, w_cur;

  rx_baud_gen #(.CLK_HZ(CLK_HZ)) u_baud (
    .clk         (clk),
    .reset       (reset),
    .baud_select (rx.baud_select),
    .o_tick      (w_tick)
  );

  assign w_cur = r_sync2;

  // Synchronizer and previous-sample flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rx.RxD;
      r_sync2 <= r_sync1;
      if (w_tick) r_prev <= w_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sc    <= '0;
      r_bc    <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_sc    <= w_sc_n;
      r_bc    <= w_bc_n;
      r_shift <= w_shift_n;
      r_par   <= w_par_n;
      r_data  <= w_data_n;
      r_valid <= w_valid_n;
      r_perr  <= w_perr_n;
      r_ferr  <= w_ferr_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_sc_n    = r_sc;
    w_bc_n    = r_bc;
    w_shift_n = r_shift;
    w_par_n   = r_par;
    w_data_n  = r_data;
    w_valid_n = 1'b0;
    w_perr_n  = 1'b0;
    w_ferr_n  = 1'b0;
    if (!rx.Rx_EN) begin
      w_state_n = IDLE;
      w_sc_n    = '0;
      w_bc_n    = '0;
    end else if (w_tick) begin
      case (r_state)
        IDLE: begin
          if (r_prev && !w_cur) begin
            w_state_n = START;
            w_sc_n    = '0;
          end
        end
        START: begin
          if (r_sc == 4'(MID_SAMPLE)) begin
            w_sc_n    = '0;
            w_bc_n    = '0;
            w_state_n = w_cur ? IDLE : DATA;
          end else begin
            w_sc_n = r_sc + 1'b1;
          end
        end
        DATA: begin
          w_sc_n = r_sc + 1'b1;
          if (r_sc == 4'(OVERSAMPLE - 1)) begin
            w_shift_n = {w_cur, r_shift[7:1]};
            if (r_bc == 3'(DATA_BITS - 1)) w_state_n = PARITY;
            else                           w_bc_n    = r_bc + 1'b1;
          end
        end
        PARITY: begin
          w_sc_n = r_sc + 1'b1;
          if (r_sc == 4'(OVERSAMPLE - 1)) begin
            w_par_n   = w_cur;
            w_state_n = STOP;
          end
        end
        STOP: begin
          w_sc_n = r_sc + 1'b1;
          if (r_sc == 4'(OVERSAMPLE - 1)) begin
            w_data_n  = r_shift;
            w_perr_n  = (r_par != ^r_shift);
            w_ferr_n  = !w_cur;
            w_valid_n = (r_par == ^r_shift) && w_cur;
            w_state_n = IDLE;
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  assign rx.Rx_DATA   = r_data;
  assign rx.Rx_VALID  = r_valid;
  assign rx.Rx_PERROR = r_perr;
  assign rx.Rx_FERROR = r_ferr;
  assign rx.rx_state  = r_state;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames are queued as expected strobes, a
// monitor pops and compares every strobe the receiver emits.
module tb_uart_receiver;
  import uart_pkg::*;

  // 3.072 MHz keeps runs short: 9600 -> DIV 20 (320 clk/bit), 115200 -> DIV 2 (32 clk/bit).
  localparam int unsigned CLK_HZ = 3_072_000;
  localparam int B_SLOW = 320;
  localparam int B_FAST = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_got, mon_exp;

  uart_receiver_if rx_if();

  uart_receiver #(.CLK_HZ(CLK_HZ)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx_if)
  );

  always #10 clk = ~clk;

  // Monitor: every strobe cycle must match the oldest expected frame.
  always @(negedge clk) begin
    if (rx_if.Rx_VALID || rx_if.Rx_PERROR || rx_if.Rx_FERROR) begin
      mon_got = {rx_if.Rx_VALID, rx_if.Rx_PERROR, rx_if.Rx_FERROR, rx_if.Rx_DATA};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe: got v/p/f=%b data=%h, required no strobe",
                 mon_got[10:8], mon_got[7:0]);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          bad++;
          $display("FAIL frame: got v/p/f=%b data=%h, required v/p/f=%b data=%h",
                   mon_got[10:8], mon_got[7:0], mon_exp[10:8], mon_exp[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic v, input logic p, input logic f, input logic [7:0] d);
    exp_q.push_back({v, p, f, d});
  endtask

  // Called just after a negedge; holds the line level for n clocks.
  task automatic drive_bit(input logic b, input int n);
    rx_if.RxD = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int n);
    drive_bit(1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(d[i], n);
    drive_bit(par, n);
    drive_bit(stp, n);
  endtask

  task automatic drain(input string name);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_data"},   32'(rx_if.Rx_DATA),   32'h0);
    check({tag, "_valid"},  32'(rx_if.Rx_VALID),  32'h0);
    check({tag, "_perror"}, 32'(rx_if.Rx_PERROR), 32'h0);
    check({tag, "_ferror"}, 32'(rx_if.Rx_FERROR), 32'h0);
    check({tag, "_state"},  32'(rx_if.rx_state),  32'(IDLE));
  endtask

  initial begin
    logic [7:0] ab;
    rx_if.RxD = 1'b1;
    rx_if.Rx_EN = 1'b1;
    rx_if.baud_select = 3'd3;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    drive_bit(1'b1, 2 * B_SLOW);

    // Good frame, then parity error (0x37 has five ones, so parity should be 1).
    expect_frame(1'b1, 1'b0, 1'b0, 8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1, B_SLOW);
    drive_bit(1'b1, B_SLOW);
    expect_frame(1'b0, 1'b1, 1'b0, 8'h37);
    send_frame(8'h37, 1'b0, 1'b1, B_SLOW);
    drive_bit(1'b1, B_SLOW);
    drain("drain_a5_37");

    // Framing error followed by a held-low line; no frame until the line goes high.
    expect_frame(1'b0, 1'b0, 1'b1, 8'h00);
    send_frame(8'h00, 1'b0, 1'b0, B_SLOW);
    drive_bit(1'b0, 3 * B_SLOW);
    check("break_state_idle", 32'(rx_if.rx_state), 32'(IDLE));
    drive_bit(1'b1, B_SLOW);
    expect_frame(1'b1, 1'b0, 1'b0, 8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1, B_SLOW);
    drive_bit(1'b1, B_SLOW);
    drain("drain_break");

    // Glitch of 4 ticks is a false start.
    drive_bit(1'b0, 80);
    drive_bit(1'b1, B_SLOW);
    check("glitch_state_idle", 32'(rx_if.rx_state), 32'(IDLE));
    check("glitch_data_hold", 32'(rx_if.Rx_DATA), 32'h5A);
    expect_frame(1'b1, 1'b0, 1'b0, 8'hFF);
    send_frame(8'hFF, 1'b0, 1'b1, B_SLOW);
    drive_bit(1'b1, B_SLOW);
    drain("drain_glitch");

    // Abort 0x81 after its 4th data bit by dropping enable.
    ab = 8'h81;
    drive_bit(1'b0, B_SLOW);
    for (int i = 0; i < 4; i++) drive_bit(ab[i], B_SLOW);
    rx_if.Rx_EN = 1'b0;
    rx_if.RxD = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_state_idle", 32'(rx_if.rx_state), 32'(IDLE));
    repeat (B_SLOW) @(negedge clk);
    check("abort_data_hold", 32'(rx_if.Rx_DATA), 32'hFF);
    rx_if.Rx_EN = 1'b1;
    drive_bit(1'b1, B_SLOW);
    expect_frame(1'b1, 1'b0, 1'b0, 8'h42);
    send_frame(8'h42, 1'b0, 1'b1, B_SLOW);
    drive_bit(1'b1, B_SLOW);
    drain("drain_abort");

    // 115200: three back-to-back frames, then reset in the middle of a fourth.
    rx_if.baud_select = 3'd7;
    drive_bit(1'b1, 2 * B_FAST);
    expect_frame(1'b1, 1'b0, 1'b0, 8'h01);
    expect_frame(1'b1, 1'b0, 1'b0, 8'h80);
    expect_frame(1'b1, 1'b0, 1'b0, 8'hC3);
    send_frame(8'h01, 1'b1, 1'b1, B_FAST);
    send_frame(8'h80, 1'b1, 1'b1, B_FAST);
    send_frame(8'hC3, 1'b0, 1'b1, B_FAST);
    drain("drain_back_to_back");
    drive_bit(1'b0, B_FAST);
    drive_bit(1'b1, B_FAST);
    drive_bit(1'b0, B_FAST);
    reset = 1'b1;
    rx_if.RxD = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("post_reset");
    drive_bit(1'b1, 8 * B_FAST);
    drain("drain_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
